// File: rtl/mem_wait_cnt_pkg.sv
// Shared sizing constants for the per-wavefront memory wait tracker.
// No logic; compile-time values only.
// Imported by the top and the per-wavefront slice.
package mem_wait_cnt_pkg;

    // Wavefronts per compute unit tracked by the issue stage.
    localparam int WF_PER_CU = 40;

    // Default wavefront id width; must cover WF_PER_CU.
    localparam int WFID_W_DEF = 6;

    // Outstanding LSU request counter width per wavefront.
    localparam int MEM_CNT_W = 4;

    // Saturation value of a counter of the given width.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/mem_wait_cnt_slice.sv
// One wavefront: outstanding counter, s_waitcnt threshold, status decode.
// Latency: state updates on the clock edge; status bits are decoded from registers.
// No backpressure; ovf/unf pulse combinationally when an event is illegal this cycle.
module mem_wait_cnt_slice
    import mem_wait_cnt_pkg::*;
#(
    parameter int CNT_W = MEM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             ld_thresh,
    input  logic [CNT_W-1:0] thresh_val,
    output logic             mem_wait,
    output logic             mem_busy,
    output logic             mem_full,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thresh;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] thresh_nxt;

    // Next-state priority: clear drops everything else; issue+done cancel;
    // a lone issue/done saturates and reports the illegal edge instead of wrapping.
    always_comb begin
        cnt_nxt    = cnt;
        thresh_nxt = thresh;
        ovf        = 1'b0;
        unf        = 1'b0;
        if (clr) begin
            cnt_nxt    = '0;
            thresh_nxt = '0;
            unf        = (cnt != '0);
        end else begin
            if (inc && !dec) begin
                if (cnt != MAX) cnt_nxt = cnt + 1'b1;
                else            ovf     = 1'b1;
            end else if (dec && !inc) begin
                if (cnt != '0) cnt_nxt = cnt - 1'b1;
                else           unf     = 1'b1;
            end
            if (ld_thresh) thresh_nxt = thresh_val;
        end
    end

    // Counter and threshold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            thresh <= '0;
        end else begin
            cnt    <= cnt_nxt;
            thresh <= thresh_nxt;
        end
    end

    // Status decode from registered state only.
    always_comb begin
        mem_wait = (cnt > thresh);
        mem_busy = (cnt != '0);
        mem_full = (cnt == MAX);
    end

endmodule

// File: rtl/mem_wait_cnt.sv
// Per-wavefront outstanding-memory-request tracker for the issue stage.
// Latency: one cycle from any event to the status arrays and error flags.
// No backpressure: issue must honour mem_full_arry the cycle before issuing.
module mem_wait_cnt
    import mem_wait_cnt_pkg::*;
#(
    parameter int NUM_WF = WF_PER_CU,
    parameter int WFID_W = WFID_W_DEF,
    parameter int CNT_W  = MEM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    input  logic [WFID_W-1:0] lsu_wfid,
    input  logic              lsu_done,
    input  logic [WFID_W-1:0] lsu_done_wfid,
    input  logic              waitcnt_valid,
    input  logic [WFID_W-1:0] waitcnt_wfid,
    input  logic [CNT_W-1:0]  waitcnt_value,
    input  logic              wf_clear,
    input  logic [WFID_W-1:0] wf_clear_wfid,
    output logic [NUM_WF-1:0] mem_wait_arry,
    output logic [NUM_WF-1:0] mem_busy_arry,
    output logic [NUM_WF-1:0] mem_full_arry,
    output logic              err_overflow,
    output logic              err_underflow
);

    logic [NUM_WF-1:0] issue_hit;
    logic [NUM_WF-1:0] done_hit;
    logic [NUM_WF-1:0] waitcnt_hit;
    logic [NUM_WF-1:0] clear_hit;
    logic [NUM_WF-1:0] ovf_vec;
    logic [NUM_WF-1:0] unf_vec;

    // One-hot decoders; ids at or above NUM_WF match no slice and are ignored.
    genvar i;
    generate
        for (i = 0; i < NUM_WF; i++) begin : g_wf
            assign issue_hit[i]   = lsu_valid     && (lsu_wfid      == WFID_W'(i));
            assign done_hit[i]    = lsu_done      && (lsu_done_wfid == WFID_W'(i));
            assign waitcnt_hit[i] = waitcnt_valid && (waitcnt_wfid  == WFID_W'(i));
            assign clear_hit[i]   = wf_clear      && (wf_clear_wfid == WFID_W'(i));

            mem_wait_cnt_slice #(
                .CNT_W (CNT_W)
            ) u_slice (
                .clk        (clk),
                .rst        (rst),
                .inc        (issue_hit[i]),
                .dec        (done_hit[i]),
                .clr        (clear_hit[i]),
                .ld_thresh  (waitcnt_hit[i]),
                .thresh_val (waitcnt_value),
                .mem_wait   (mem_wait_arry[i]),
                .mem_busy   (mem_busy_arry[i]),
                .mem_full   (mem_full_arry[i]),
                .ovf        (ovf_vec[i]),
                .unf        (unf_vec[i])
            );
        end
    endgenerate

    // Sticky protocol error flags; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= err_overflow  | (|ovf_vec);
            err_underflow <= err_underflow | (|unf_vec);
        end
    end

endmodule

// File: doc/mem_wait_cnt.md
# mem_wait_cnt

Per-wavefront outstanding-memory-request tracker for the issue stage; the counting successor to the single-bit memory wait flag. It keeps an up/down counter per wavefront instead of one bit, so several LSU requests per wavefront can be in flight. It holds a per-wavefront s_waitcnt threshold and asserts wait only while outstanding > threshold. It also reports full and busy per wavefront and flags protocol errors.

## Interface
- NUM_WF, default 40 (`WF_PER_CU`): wavefronts tracked.
- WFID_W, default 6: wavefront id width; NUM_WF ≤ 2^WFID_W.
- CNT_W, default 4: counter width; MAX = 2^CNT_W−1 outstanding per wavefront.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- lsu_valid  in  1  LSU request issued for lsu_wfid.
- lsu_wfid  in  WFID_W  issuing wavefront.
- lsu_done  in  1  LSU request retired for lsu_done_wfid.
- lsu_done_wfid  in  WFID_W  retiring wavefront.
- waitcnt_valid  in  1  s_waitcnt issued; load threshold.
- waitcnt_wfid  in  WFID_W  target wavefront.
- waitcnt_value  in  CNT_W  allowed outstanding count.
- wf_clear  in  1  wavefront slot (re)allocated; zero its state.
- wf_clear_wfid  in  WFID_W  slot to clear.
- mem_wait_arry  out  NUM_WF  bit i = cnt[i] > thresh[i].
- mem_busy_arry  out  NUM_WF  bit i = cnt[i] != 0.
- mem_full_arry  out  NUM_WF  bit i = cnt[i] == MAX; issue must not send LSU ops for i.
- err_overflow  out  1  sticky: issue to full wavefront.
- err_underflow  out  1  sticky: done to empty wavefront, or clear of busy wavefront.

## Operation
- State per wavefront: cnt[CNT_W], thresh[CNT_W]; two sticky error bits. All outputs are decoded from registered state with no input-to-output paths.
- Reset: all cnt = 0 and thresh = 0, so every output array is 0. err_* = 0.
- Any wfid ≥ NUM_WF is ignored (no update, no error).
- Per wavefront i, each cycle, evaluated in priority order:
  - clear hit: cnt ← 0 and thresh ← 0. Issue, done and waitcnt hitting i this cycle are dropped with no error. If the old cnt ≠ 0, set err_underflow.
  - issue hit and done hit: cnt unchanged, including at 0 and MAX, with no error.
  - issue hit only: if cnt < MAX, cnt+1. Otherwise cnt holds and err_overflow is set.
  - done hit only: if cnt > 0, cnt−1. Otherwise cnt holds and err_underflow is set.
  - waitcnt hit: thresh ← waitcnt_value. This is independent of count updates in the same cycle.
- thresh is sticky until rewritten or cleared. With thresh = 0, the block reproduces the legacy single-bit behaviour: wait whenever anything is outstanding.
- Counts never wrap.
- err_* bits stay set until rst.

## Timing
- Single-cycle update: an event at edge N is visible on outputs after edge N (cycle N+1). There is no further latency.
- Issue at cycle N and done for the same wavefront at N+1 (shortest LSU): mem_wait_arry is high for exactly cycle N+1 and low from N+2.
- Issue and done for different wavefronts in the same cycle update both independently.
- waitcnt and done in the same cycle: the new thresh is compared against the new cnt from N+1.
- Asynchronous reset mid-operation: outputs go to 0 immediately. In-flight retirements arriving after reset deassertion hit cnt = 0 and set err_underflow; this is expected and is the verifier's check.
- No handshake back-pressure. The issue stage must sample mem_full_arry the cycle before issuing.

## Structure
- Shared global header gets `WF_PER_CU`, the default WFID_W, and a MEM_CNT_W define for the counter width. No new package types.
- Sub-module mem_wait_cnt_slice holds one wavefront's cnt/thresh, next-state priority logic and the three status bits. It has per-slice inc/dec/clr/ld_thresh inputs and ovf/unf pulse outputs.
- The top instantiates NUM_WF slices (generate loop). It contains four parametrised one-hot decoders (issue, done, waitcnt, clear) and OR-reduces the slice error pulses into the sticky flops.

## Test plan
- Reset then idle: all arrays are 0 and err_* = 0. Assert rst mid-run with cnt[3] = 5: arrays are 0 immediately.
- Three issues to wf 7 on consecutive cycles, then three dones: cnt goes 1,2,3,2,1,0. mem_wait_arry[7] is high cycles 1–5, and mem_busy_arry tracks it.
- waitcnt wf 2 = 2, then four issues to wf 2: wait is low at cnt 1–2 and high at cnt 3–4. After two dones (cnt = 2), wait is low.
- Fifteen issues to wf 39 (CNT_W = 4): full high at cnt = 15. A 16th issue leaves cnt = 15 and sets err_overflow. A done on empty wf 0 sets err_underflow.
- Same-cycle issue + done to wf 5 at cnt = 0 and at cnt = 15: cnt unchanged, no error. Issue wf 1 + done wf 9 in the same cycle: both update.
- wf_clear wf 4 with cnt = 3 and thresh = 1, together with an issue to wf 4: cnt = 0, thresh = 0, err_underflow set, issue dropped. Ids 40–63 cause no change.
